cook_timer: RTL and testbench
=============================

Name: cook_timer

Overview:
Countdown cook timer for the microwave: holds the programmed cook time as BCD mm:ss and decrements once per second while the magnetron is energised. It asserts timer_done, which the magnetron control logic uses to reset the magnetron latch. It sits between the keypad/load path and the magnetron control block, and drives the time display.

Parameters:
TICKS_PER_SEC, 1000, clk cycles per one-second tick (minimum 2).

Ports:
clk  input  1  system clock; all state updates on the rising edge
resetn  input  1  asynchronous active-low reset
clearn  input  1  synchronous active-low clear, level-sensitive (same keypad Clear as the magnetron logic)
load  input  1  one-cycle pulse; capture load_bcd
load_bcd  input  16  cook time in BCD {min_tens, min_units, sec_tens, sec_units}
mag_on  input  1  magnetron latch Q; 1 = heating
time_bcd  output  16  current remaining time in BCD, same format as load_bcd
timer_done  output  1  registered; 1 while in DONE
running  output  1  registered; 1 while in RUN
sec_tick  output  1  one-cycle pulse on each decrement
load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (resetn=0, async): state IDLE, count 0x0000, prescaler 0, and all outputs 0.
- States:
  - IDLE: count==0, not done.
  - ARMED: count>0, magnetron off.
  - RUN: counting.
  - DONE: expired.
- Priority each cycle: clearn=0 > load > mag_on/tick.
- clearn=0 in any state: count<=0, prescaler<=0, state<=IDLE. Overrides a same-cycle load or tick.
- Load validity:
  - Every digit must be <=9 and sec_tens must be <=5.
  - Invalid load: count is unchanged, state is unchanged, and load_err pulses the next cycle.
  - Valid load in IDLE/ARMED/DONE: count<=load_bcd and prescaler<=0.
  - After a valid load, state<=ARMED if the value is nonzero, else IDLE.
  - Load in RUN is ignored, with no load_err.
- IDLE with mag_on=1 (zero-time start): state<=DONE next edge.
- ARMED with mag_on=1: state<=RUN. The prescaler keeps its value.
- RUN behaviour:
  - mag_on=0: state<=ARMED, with the prescaler frozen (pause/resume keeps partial-second progress).
  - mag_on=1 and prescaler==TICKS_PER_SEC-1: this is a tick. prescaler<=0, count<=dec(count), and sec_tick pulses.
  - If dec(count)==0x0000, state<=DONE on the same edge.
  - Otherwise, with mag_on=1, the prescaler increments.
- A tick and a falling mag_on in the same cycle: the pause wins and there is no decrement.
- Decrement dec() (BCD mm:ss with borrow):
  - sec_units 0 -> 9 with borrow; sec_tens 0 -> 5 with borrow.
  - min_units 0 -> 9 with borrow; min_tens decrements.
  - dec() is never applied to 0x0000.
- DONE: timer_done=1 and count=0x0000; mag_on is ignored. Leaves DONE only by clearn=0 (to IDLE) or a valid load.
- Latency:
  - timer_done and time_bcd update on the same edge as the final tick, and are visible the following cycle.
  - running follows the state register.
- Maximum count is 0x9959, which is 5999 s.

Decomposition:
- Shared package mw_pkg holds:
  - the state encoding (IDLE, ARMED, RUN, DONE);
  - the BCD field widths and bit positions;
  - the constants SEC_TENS_MAX=5 and DIGIT_MAX=9.
- One natural sub-module, bcd_mmss_dec: combinational BCD mm:ss decrement plus a validity check on a 16-bit value.

Test Plan (TICKS_PER_SEC=4):
1. Assert resetn=0 mid-RUN -> all outputs 0 immediately. After release, state is IDLE and time_bcd=0x0000.
2. Load 0x0002, then hold mag_on=1 -> running=1, time_bcd=0x0001 after 4 RUN cycles, then 0x0000 with timer_done=1 after 8, then sec_tick pulses twice.
3. Load 0x0100 and run one tick -> time_bcd=0x0059. Load 0x1000 and run one tick -> 0x0959.
4. Load 0x0005 and run with mag_on=1 for 2 cycles. Drop mag_on for 10 cycles -> running=0, time_bcd still 0x0005. Raise mag_on -> tick after 2 more cycles, giving 0x0004.
5. Load 0x0070 or 0x00A1 -> load_err pulses, time_bcd unchanged. Load while running -> ignored, no load_err.
6. In RUN, clearn=0 on a tick cycle -> time_bcd=0x0000, state IDLE, no sec_tick. From DONE, load 0x0030 -> timer_done=0 and time_bcd=0x0030. From IDLE with mag_on=1 -> timer_done=1 next cycle.

Source files
------------

// File: rtl/mw_pkg.sv
// Shared definitions for the microwave cook timer: state encoding and BCD mm:ss layout.
package mw_pkg;

    localparam int unsigned BCD_W         = 16;
    localparam int unsigned DIGIT_W       = 4;

    localparam int unsigned SEC_UNITS_LSB = 0;
    localparam int unsigned SEC_TENS_LSB  = 4;
    localparam int unsigned MIN_UNITS_LSB = 8;
    localparam int unsigned MIN_TENS_LSB  = 12;

    localparam int unsigned SEC_TENS_MAX  = 5;
    localparam int unsigned DIGIT_MAX     = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // True when a BCD digit does not exceed the given limit.
    function automatic logic digit_ok(input logic [DIGIT_W-1:0] d, input int unsigned lim);
        return d <= DIGIT_W'(lim);
    endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational BCD mm:ss decrement with borrow, plus a range check on a second value.
module bcd_mmss_dec
    import mw_pkg::*;
(
    input  logic [BCD_W-1:0] i_count,
    input  logic [BCD_W-1:0] i_chk,
    output logic [BCD_W-1:0] o_dec,
    output logic             o_dec_zero,
    output logic             o_chk_valid
);

    logic [DIGIT_W-1:0] w_su;
    logic [DIGIT_W-1:0] w_st;
    logic [DIGIT_W-1:0] w_mu;
    logic [DIGIT_W-1:0] w_mt;
    logic [DIGIT_W-1:0] w_su_n;
    logic [DIGIT_W-1:0] w_st_n;
    logic [DIGIT_W-1:0] w_mu_n;
    logic [DIGIT_W-1:0] w_mt_n;
    logic               w_b_su;
    logic               w_b_st;
    logic               w_b_mu;

    // Ripple the borrow from seconds units up to minutes tens.
    always_comb begin
        w_su   = i_count[SEC_UNITS_LSB +: DIGIT_W];
        w_st   = i_count[SEC_TENS_LSB  +: DIGIT_W];
        w_mu   = i_count[MIN_UNITS_LSB +: DIGIT_W];
        w_mt   = i_count[MIN_TENS_LSB  +: DIGIT_W];

        w_b_su = (w_su == '0);
        w_su_n = w_b_su ? DIGIT_W'(DIGIT_MAX) : (w_su - DIGIT_W'(1));

        w_b_st = w_b_su && (w_st == '0);
        w_st_n = w_st;
        if (w_b_su) begin
            w_st_n = (w_st == '0) ? DIGIT_W'(SEC_TENS_MAX) : (w_st - DIGIT_W'(1));
        end

        w_b_mu = w_b_st && (w_mu == '0);
        w_mu_n = w_mu;
        if (w_b_st) begin
            w_mu_n = (w_mu == '0) ? DIGIT_W'(DIGIT_MAX) : (w_mu - DIGIT_W'(1));
        end

        w_mt_n = w_b_mu ? (w_mt - DIGIT_W'(1)) : w_mt;

        o_dec = '0;
        o_dec[SEC_UNITS_LSB +: DIGIT_W] = w_su_n;
        o_dec[SEC_TENS_LSB  +: DIGIT_W] = w_st_n;
        o_dec[MIN_UNITS_LSB +: DIGIT_W] = w_mu_n;
        o_dec[MIN_TENS_LSB  +: DIGIT_W] = w_mt_n;
        o_dec_zero = (o_dec == '0);
    end

    // A loadable time has every digit <= 9 and seconds tens <= 5.
    always_comb begin
        o_chk_valid = digit_ok(i_chk[SEC_UNITS_LSB +: DIGIT_W], DIGIT_MAX)
                   && digit_ok(i_chk[SEC_TENS_LSB  +: DIGIT_W], SEC_TENS_MAX)
                   && digit_ok(i_chk[MIN_UNITS_LSB +: DIGIT_W], DIGIT_MAX)
                   && digit_ok(i_chk[MIN_TENS_LSB  +: DIGIT_W], DIGIT_MAX);
    end

endmodule

// File: rtl/cook_timer.sv
// Microwave cook timer: BCD mm:ss countdown, one decrement per second while heating.
module cook_timer
    import mw_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clearn,
    input  logic              load,
    input  logic [BCD_W-1:0]  load_bcd,
    input  logic              mag_on,
    output logic [BCD_W-1:0]  time_bcd,
    output logic              timer_done,
    output logic              running,
    output logic              sec_tick,
    output logic              load_err
);

    localparam int unsigned        PRESC_W   = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

    state_t             r_state;
    logic [BCD_W-1:0]   r_count;
    logic [PRESC_W-1:0] r_presc;
    logic               r_timer_done;
    logic               r_running;
    logic               r_sec_tick;
    logic               r_load_err;

    state_t             w_state_nx;
    logic [BCD_W-1:0]   w_count_nx;
    logic [PRESC_W-1:0] w_presc_nx;
    logic               w_tick;
    logic               w_load_err;
    logic [BCD_W-1:0]   w_dec;
    logic               w_dec_zero;
    logic               w_load_ok;

    bcd_mmss_dec u_dec (
        .i_count     (r_count),
        .i_chk       (load_bcd),
        .o_dec       (w_dec),
        .o_dec_zero  (w_dec_zero),
        .o_chk_valid (w_load_ok)
    );

    // Next state: clear beats load, load (outside RUN) beats magnetron/tick handling.
    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_presc_nx = r_presc;
        w_tick     = 1'b0;
        w_load_err = 1'b0;

        if (!clearn) begin
            w_state_nx = ST_IDLE;
            w_count_nx = '0;
            w_presc_nx = '0;
        end else if (load && (r_state != ST_RUN)) begin
            if (w_load_ok) begin
                w_count_nx = load_bcd;
                w_presc_nx = '0;
                w_state_nx = (load_bcd == '0) ? ST_IDLE : ST_ARMED;
            end else begin
                w_load_err = 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mag_on) begin
                        w_state_nx = ST_DONE;
                    end
                end
                ST_ARMED: begin
                    if (mag_on) begin
                        w_state_nx = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Pausing freezes the prescaler so partial seconds survive a door open.
                    if (!mag_on) begin
                        w_state_nx = ST_ARMED;
                    end else if (r_presc == PRESC_MAX) begin
                        w_tick     = 1'b1;
                        w_presc_nx = '0;
                        w_count_nx = w_dec;
                        if (w_dec_zero) begin
                            w_state_nx = ST_DONE;
                        end
                    end else begin
                        w_presc_nx = r_presc + PRESC_W'(1);
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, prescaler and registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_presc      <= '0;
            r_timer_done <= 1'b0;
            r_running    <= 1'b0;
            r_sec_tick   <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_count      <= w_count_nx;
            r_presc      <= w_presc_nx;
            r_timer_done <= (w_state_nx == ST_DONE);
            r_running    <= (w_state_nx == ST_RUN);
            r_sec_tick   <= w_tick;
            r_load_err   <= w_load_err;
        end
    end

    assign time_bcd   = r_count;
    assign timer_done = r_timer_done;
    assign running    = r_running;
    assign sec_tick   = r_sec_tick;
    assign load_err   = r_load_err;

endmodule

// File: tb/tb_cook_timer.sv
// Self-checking bench for cook_timer with a one-second period of four clocks.
module tb_cook_timer;

    localparam int unsigned TPS = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clearn;
    logic        load;
    logic [15:0] load_bcd;
    logic        mag_on;
    logic [15:0] time_bcd;
    logic        timer_done;
    logic        running;
    logic        sec_tick;
    logic        load_err;

    // ctl = {clearn, load, mag_on}; f = {timer_done, running, sec_tick, load_err}
    typedef struct packed {
        logic [2:0]  ctl;
        logic [15:0] bcd;
        logic [15:0] t;
        logic [3:0]  f;
    } row_t;

    logic [19:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    cook_timer #(.TICKS_PER_SEC(TPS)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clearn     (clearn),
        .load       (load),
        .load_bcd   (load_bcd),
        .mag_on     (mag_on),
        .time_bcd   (time_bcd),
        .timer_done (timer_done),
        .running    (running),
        .sec_tick   (sec_tick),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input logic [2:0] ctl, input logic [15:0] bcd,
                                input logic [15:0] t, input logic [3:0] f);
        row_t r;
        r.ctl = ctl;
        r.bcd = bcd;
        r.t   = t;
        r.f   = f;
        return r;
    endfunction

    function automatic logic [19:0] obs();
        return {time_bcd, timer_done, running, sec_tick, load_err};
    endfunction

    // Apply one cycle of stimulus and queue what the outputs must show after the edge.
    task automatic drive(input row_t r);
        clearn   = r.ctl[2];
        load     = r.ctl[1];
        mag_on   = r.ctl[0];
        load_bcd = r.bcd;
        sb.push_back({r.t, r.f});
    endtask

    task automatic test_reset();
        row_t        v[$];
        row_t        w[$];
        logic [19:0] e;
        sb.push_back(20'h0);
        e = sb.pop_front();
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL reset_por: got %h want %h", obs(), e);
        end
        v.push_back(mk(3'b110, 16'h0003, 16'h0003, 4'b0000));
        v.push_back(mk(3'b101, 16'h0000, 16'h0003, 4'b0100));
        v.push_back(mk(3'b101, 16'h0000, 16'h0003, 4'b0100));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL reset_run[%0d]: got %h want %h", i, obs(), e);
            end
        end
        resetn = 1'b0;
        sb.push_back(20'h0);
        #1;
        e = sb.pop_front();
        n_vec++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL reset_async: got %h want %h", obs(), e);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        w.push_back(mk(3'b100, 16'h0000, 16'h0000, 4'b0000));
        w.push_back(mk(3'b101, 16'h0000, 16'h0000, 4'b1000));
        w.push_back(mk(3'b000, 16'h0000, 16'h0000, 4'b0000));
        foreach (w[i]) begin
            drive(w[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: got %h want %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_countdown();
        row_t        v[$];
        logic [19:0] e;
        v.push_back(mk(3'b110, 16'h0002, 16'h0002, 4'b0000));
        repeat (4) v.push_back(mk(3'b101, 16'h0000, 16'h0002, 4'b0100));
        v.push_back(mk(3'b101, 16'h0000, 16'h0001, 4'b0110));
        repeat (3) v.push_back(mk(3'b101, 16'h0000, 16'h0001, 4'b0100));
        v.push_back(mk(3'b101, 16'h0000, 16'h0000, 4'b1010));
        v.push_back(mk(3'b101, 16'h0000, 16'h0000, 4'b1000));
        v.push_back(mk(3'b100, 16'h0000, 16'h0000, 4'b1000));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL countdown[%0d]: got %h want %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_borrow();
        row_t        v[$];
        logic [19:0] e;
        v.push_back(mk(3'b110, 16'h0100, 16'h0100, 4'b0000));
        repeat (4) v.push_back(mk(3'b101, 16'h0000, 16'h0100, 4'b0100));
        v.push_back(mk(3'b101, 16'h0000, 16'h0059, 4'b0110));
        v.push_back(mk(3'b100, 16'h0000, 16'h0059, 4'b0000));
        v.push_back(mk(3'b110, 16'h1000, 16'h1000, 4'b0000));
        repeat (4) v.push_back(mk(3'b101, 16'h0000, 16'h1000, 4'b0100));
        v.push_back(mk(3'b101, 16'h0000, 16'h0959, 4'b0110));
        v.push_back(mk(3'b100, 16'h0000, 16'h0959, 4'b0000));
        v.push_back(mk(3'b110, 16'h9959, 16'h9959, 4'b0000));
        v.push_back(mk(3'b110, 16'h0000, 16'h0000, 4'b0000));
        v.push_back(mk(3'b101, 16'h0000, 16'h0000, 4'b1000));
        v.push_back(mk(3'b100, 16'h0000, 16'h0000, 4'b1000));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL borrow[%0d]: got %h want %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_pause();
        row_t        v[$];
        logic [19:0] e;
        v.push_back(mk(3'b110, 16'h0005, 16'h0005, 4'b0000));
        repeat (3)  v.push_back(mk(3'b101, 16'h0000, 16'h0005, 4'b0100));
        repeat (10) v.push_back(mk(3'b100, 16'h0000, 16'h0005, 4'b0000));
        repeat (2)  v.push_back(mk(3'b101, 16'h0000, 16'h0005, 4'b0100));
        v.push_back(mk(3'b101, 16'h0000, 16'h0004, 4'b0110));
        repeat (3)  v.push_back(mk(3'b101, 16'h0000, 16'h0004, 4'b0100));
        v.push_back(mk(3'b100, 16'h0000, 16'h0004, 4'b0000));
        v.push_back(mk(3'b101, 16'h0000, 16'h0004, 4'b0100));
        v.push_back(mk(3'b101, 16'h0000, 16'h0003, 4'b0110));
        v.push_back(mk(3'b100, 16'h0000, 16'h0003, 4'b0000));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL pause[%0d]: got %h want %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_load_err();
        row_t        v[$];
        logic [19:0] e;
        v.push_back(mk(3'b110, 16'h0070, 16'h0003, 4'b0001));
        v.push_back(mk(3'b100, 16'h0000, 16'h0003, 4'b0000));
        v.push_back(mk(3'b110, 16'h00A1, 16'h0003, 4'b0001));
        v.push_back(mk(3'b110, 16'h0A00, 16'h0003, 4'b0001));
        v.push_back(mk(3'b110, 16'hA000, 16'h0003, 4'b0001));
        v.push_back(mk(3'b100, 16'h0000, 16'h0003, 4'b0000));
        v.push_back(mk(3'b101, 16'h0000, 16'h0003, 4'b0100));
        v.push_back(mk(3'b111, 16'h0050, 16'h0003, 4'b0100));
        v.push_back(mk(3'b111, 16'h00F0, 16'h0003, 4'b0100));
        v.push_back(mk(3'b101, 16'h0000, 16'h0003, 4'b0100));
        v.push_back(mk(3'b101, 16'h0000, 16'h0002, 4'b0110));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL load_err[%0d]: got %h want %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_clear_done();
        row_t        v[$];
        logic [19:0] e;
        repeat (3) v.push_back(mk(3'b101, 16'h0000, 16'h0002, 4'b0100));
        v.push_back(mk(3'b001, 16'h0000, 16'h0000, 4'b0000));
        v.push_back(mk(3'b100, 16'h0000, 16'h0000, 4'b0000));
        v.push_back(mk(3'b101, 16'h0000, 16'h0000, 4'b1000));
        v.push_back(mk(3'b110, 16'h0030, 16'h0030, 4'b0000));
        v.push_back(mk(3'b010, 16'h0040, 16'h0000, 4'b0000));
        v.push_back(mk(3'b001, 16'h0000, 16'h0000, 4'b0000));
        v.push_back(mk(3'b100, 16'h0000, 16'h0000, 4'b0000));
        v.push_back(mk(3'b110, 16'h0001, 16'h0001, 4'b0000));
        repeat (4) v.push_back(mk(3'b101, 16'h0000, 16'h0001, 4'b0100));
        v.push_back(mk(3'b101, 16'h0000, 16'h0000, 4'b1010));
        foreach (v[i]) begin
            drive(v[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL clear_done[%0d]: got %h want %h", i, obs(), e);
            end
        end
    endtask

    initial begin
        resetn   = 1'b0;
        clearn   = 1'b1;
        load     = 1'b0;
        load_bcd = 16'h0000;
        mag_on   = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        test_reset();
        test_countdown();
        test_borrow();
        test_pause();
        test_load_err();
        test_clear_done();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
